// File: rtl/uart_tx_ctrl.sv
// uart_tx_ctrl: UART frame sequencer that drives an external serializer and a registered TX line.
// Define UART_TX_TWO_STOP_EN to send two stop bits per frame.
module uart_tx_ctrl #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  Data_Valid,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic                  ser_done,
    input  logic                  ser_data,
    output logic                  ser_en,
    output logic                  TX_OUT,
    output logic                  Busy
);
`ifdef UART_TX_TWO_STOP_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, STOP2} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`endif
    state_t state, next;
    logic par_reg, par_en_r, line, accept;
    // A word is taken from IDLE or from the final stop bit, giving gapless back-to-back frames
`ifdef UART_TX_TWO_STOP_EN
    assign accept = Data_Valid && (state == IDLE || state == STOP2);
`else
    assign accept = Data_Valid && (state == IDLE || state == STOP);
`endif
    always_ff @(posedge CLK) begin
        if (!RST)
            state <= IDLE;
        else
            state <= next;
    end
    always_comb begin
        next = state;
        case (state)
            IDLE:    next = accept ? START : IDLE;
            START:   next = DATA;
            DATA:    next = ser_done ? (par_en_r ? PARITY : STOP) : DATA;
            PARITY:  next = STOP;
`ifdef UART_TX_TWO_STOP_EN
            STOP:    next = STOP2;
            STOP2:   next = accept ? START : IDLE;
`else
            STOP:    next = accept ? START : IDLE;
`endif
            default: next = IDLE;
        endcase
    end
    always_comb begin
        ser_en = state == START || (state == DATA && !ser_done);
        line   = state == START  ? 1'b0 :
                 state == DATA   ? ser_data :
                 state == PARITY ? par_reg : 1'b1;
    end
    always_ff @(posedge CLK) begin
        if (!RST) begin
            TX_OUT   <= 1'b1;
            Busy     <= 1'b0;
            par_reg  <= 1'b0;
            par_en_r <= 1'b0;
        end else begin
            TX_OUT <= line;
            Busy   <= state != IDLE;
            if (accept) begin
                par_reg  <= ^P_DATA ^ PAR_TYP;
                par_en_r <= PAR_EN;
            end
        end
    end
endmodule

// File: tb/tb_uart_tx_ctrl.sv
// tb_uart_tx_ctrl: frame-queue reference model, serializer stand-in, directed and random stimulus.
module tb_uart_tx_ctrl;
    localparam int W = 8;
`ifdef UART_TX_TWO_STOP_EN
    localparam int NSTOP = 2;
`else
    localparam int NSTOP = 1;
`endif
    logic clk = 0, rst = 0, dv = 0, par_en = 0, par_typ = 0;
    logic [W-1:0] p_data = '0;
    logic ser_done, ser_data, ser_en, tx_out, busy;
    int tests = 0, fails = 0;

    always #5 clk = ~clk;

    uart_tx_ctrl #(.DATA_WIDTH(W)) dut (
        .CLK(clk), .RST(rst), .P_DATA(p_data), .Data_Valid(dv), .PAR_EN(par_en),
        .PAR_TYP(par_typ), .ser_done(ser_done), .ser_data(ser_data), .ser_en(ser_en),
        .TX_OUT(tx_out), .Busy(busy)
    );

    // Serializer stand-in: loads while disabled, presents bit idx-1 after idx enabled cycles
    logic [W-1:0] sh = '0;
    int idx = 0;
    always @(posedge clk) begin
        if (!ser_en) begin
            sh  <= p_data;
            idx <= 0;
        end else
            idx <= idx + 1;
    end
    assign ser_data = (idx >= 1 && idx <= W) ? sh[idx-1] : 1'b0;
    assign ser_done = idx == W;

    // Reference: queue of line bits still to be sent, one per clock, each tagged with expected ser_en
    typedef struct packed {logic b; logic en;} slot_t;
    slot_t q[$];
    logic exp_tx = 1'b1, exp_busy = 1'b0, armed = 1'b0;
    always @(posedge clk) begin
        if (!rst) begin
            q.delete();
            exp_tx   <= 1'b1;
            exp_busy <= 1'b0;
            armed    <= 1'b1;
        end else begin
            exp_tx   <= q.size() != 0 ? q[0].b : 1'b1;
            exp_busy <= q.size() != 0;
            if (dv && q.size() <= 1) begin
                q.delete();
                q.push_back(slot_t'{b: 1'b0, en: 1'b1});
                for (int i = 0; i < W; i++) q.push_back(slot_t'{b: p_data[i], en: i < W - 1});
                if (par_en) q.push_back(slot_t'{b: ^p_data ^ par_typ, en: 1'b0});
                for (int i = 0; i < NSTOP; i++) q.push_back(slot_t'{b: 1'b1, en: 1'b0});
            end else if (q.size() != 0)
                void'(q.pop_front());
        end
    end

    task automatic check(input string nm, input logic a, input logic e);
        tests++;
        if (a !== e) begin
            fails++;
            $display("FAIL %s at %0t: got %b expected %b", nm, $time, a, e);
        end
    endtask

    task automatic check_int(input string nm, input int a, input int e);
        tests++;
        if (a != e) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, a, e);
        end
    endtask

    always @(negedge clk) begin
        if (armed) begin
            check("tx_out", tx_out, exp_tx);
            check("busy", busy, exp_busy);
            check("ser_en", ser_en, q.size() != 0 ? q[0].en : 1'b0);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send(input logic [W-1:0] d, input logic pe, input logic pt);
        p_data = d; par_en = pe; par_typ = pt; dv = 1'b1;
        @(negedge clk);
        dv = 1'b0;
    endtask

    // Collects TX_OUT while Busy is high; n stays 0 if Busy never rises within the budget
    task automatic capture(output logic [31:0] bits, output int n);
        int t;
        t = 0; bits = '0; n = 0;
        while (!busy && t < 20) begin
            @(negedge clk);
            t++;
        end
        while (busy && n < 32) begin
            bits[n] = tx_out;
            n++;
            @(negedge clk);
        end
    endtask

    function automatic int stopx(input int base, input int len);
        return NSTOP == 2 ? base | (1 << len) : base;
    endfunction

    logic [31:0] bits;
    int n;
    initial begin
        tick(2);
        check("reset_tx", tx_out, 1'b1);
        check("reset_busy", busy, 1'b0);
        check("reset_ser_en", ser_en, 1'b0);
        rst = 1'b1;
        tick(2);

        send(8'hA5, 1'b0, 1'b0);
        capture(bits, n);
        check_int("a5_bits", int'(bits), stopx(32'h34A, 10));
        check_int("a5_len", n, 9 + NSTOP);

        send(8'hA5, 1'b1, 1'b0);
        capture(bits, n);
        check_int("a5_even_bits", int'(bits), stopx(32'h54A, 11));
        check_int("a5_even_len", n, 10 + NSTOP);
        send(8'hA5, 1'b1, 1'b1);
        capture(bits, n);
        check_int("a5_odd_bits", int'(bits), stopx(32'h74A, 11));
        check_int("a5_odd_len", n, 10 + NSTOP);

        p_data = 8'h00; par_en = 1'b0; dv = 1'b1;
        fork
            begin
                tick(1);
                p_data = 8'hFF;
                tick(9 + NSTOP);
                dv = 1'b0;
            end
            capture(bits, n);
        join
`ifdef UART_TX_TWO_STOP_EN
        check_int("b2b_bits", int'(bits), 32'h3FF600);
        check_int("b2b_len", n, 22);
`else
        check_int("b2b_bits", int'(bits), 32'hFFA00);
        check_int("b2b_len", n, 20);
`endif
        tick(3);

        send(8'h3C, 1'b0, 1'b0);
        tick(4);
        rst = 1'b0;
        tick(1);
        check("abort_tx", tx_out, 1'b1);
        check("abort_busy", busy, 1'b0);
        check("abort_ser_en", ser_en, 1'b0);
        rst = 1'b1;
        tick(2);
        send(8'h55, 1'b0, 1'b0);
        capture(bits, n);
        check_int("post_abort_bits", int'(bits), stopx(32'h2AA, 10));

        send(8'hA5, 1'b1, 1'b0);
        fork
            capture(bits, n);
            begin
                tick(3);
                dv = 1'b1; par_typ = 1'b1;
                tick(1);
                dv = 1'b0;
                tick(4);
                dv = 1'b1;
                tick(2);
                dv = 1'b0;
            end
        join
        check_int("ignore_bits", int'(bits), stopx(32'h54A, 11));
        check_int("ignore_len", n, 10 + NSTOP);
        tick(3);
        check("ignore_no_extra", busy, 1'b0);

`ifdef UART_TX_TWO_STOP_EN
        send(8'h81, 1'b1, 1'b1);
        capture(bits, n);
        check_int("two_stop_bits", int'(bits), 32'hF02);
        check_int("two_stop_len", n, 12);
`endif

        for (int c = 0; c < 3000; c++) begin
            dv      = $urandom_range(0, 3) == 0;
            p_data  = W'($urandom);
            par_en  = 1'($urandom);
            par_typ = 1'($urandom);
            rst     = $urandom_range(0, 199) != 0;
            tick(1);
        end
        rst = 1'b1; dv = 1'b0;
        tick(20);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
